// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour HH:MM:SS time-of-day keeper in packed BCD.
// A prescaler divides clk down to a 1 s tick. A set mode adjusts minutes and
// hours from push-button pulses. Registered one-cycle pulses mark second
// ticks, minute changes and the midnight wrap.
// Optional build macro LEADING_ZERO_BLANK_EN: hour_tens shows the decoder
// blank code 4'ha whenever the hour-tens digit is zero.
module bcd_time_counter #(
  parameter int CLK_DIV = 50000000,
  parameter int PS_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       day_wrap
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] HT_DISP_RST = 4'ha;
`else
  localparam logic [3:0] HT_DISP_RST = 4'h0;
`endif

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_SET  = 2'd2
  } mode_e;

  mode_e mode;

  logic [PS_W-1:0] ps_q, ps_d;
  logic [3:0] ht_q, ht_d, ho_q, ho_d;
  logic [3:0] mt_q, mt_d, mo_q, mo_d;
  logic [3:0] st_q, st_d, so_q, so_d;
  logic [3:0] ht_disp_q, ht_disp_d;
  logic       sec_tick_q, sec_tick_d;
  logic       min_tick_q, min_tick_d;
  logic       day_wrap_q, day_wrap_d;
  logic [8:0] hour_nx;
  logic [8:0] min_nx;

  // Advance a 00..23 hour pair; returns {wrapped, tens, ones}.
  function automatic logic [8:0] hour_next(input logic [3:0] t, input logic [3:0] o);
    logic [8:0] r;
    if (t == 4'd2 && o == 4'd3) r = {1'b1, 4'd0, 4'd0};
    else if (o == 4'd9)         r = {1'b0, t + 4'd1, 4'd0};
    else                        r = {1'b0, t, o + 4'd1};
    return r;
  endfunction

  // Advance a 00..59 minute or second pair; returns {wrapped, tens, ones}.
  function automatic logic [8:0] sexa_next(input logic [3:0] t, input logic [3:0] o);
    logic [8:0] r;
    if (o != 4'd9)        r = {1'b0, t, o + 4'd1};
    else if (t == 4'd5)   r = {1'b1, 4'd0, 4'd0};
    else                  r = {1'b0, t + 4'd1, 4'd0};
    return r;
  endfunction

  // Hour-tens as presented to the decoder, blank code for a leading zero if enabled.
  function automatic logic [3:0] ht_display(input logic [3:0] t);
`ifdef LEADING_ZERO_BLANK_EN
    return (t == 4'd0) ? 4'ha : t;
`else
    return t;
`endif
  endfunction

  // Mode decode: set mode dominates, then run versus hold.
  always_comb begin
    if (set_mode)  mode = MODE_SET;
    else if (run)  mode = MODE_RUN;
    else           mode = MODE_HOLD;
  end

  // Next-state: prescaler, BCD carry chain, set-mode adjustment and pulses.
  always_comb begin
    ps_d       = ps_q;
    ht_d       = ht_q;
    ho_d       = ho_q;
    mt_d       = mt_q;
    mo_d       = mo_q;
    st_d       = st_q;
    so_d       = so_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    hour_nx    = hour_next(ht_q, ho_q);
    min_nx     = sexa_next(mt_q, mo_q);
    unique case (mode)
      MODE_SET: begin
        ps_d = '0;
        st_d = 4'd0;
        so_d = 4'd0;
        if (inc_min) begin
          mt_d       = min_nx[7:4];
          mo_d       = min_nx[3:0];
          min_tick_d = 1'b1;
        end
        if (inc_hour) begin
          ht_d = hour_nx[7:4];
          ho_d = hour_nx[3:0];
        end
      end
      MODE_RUN: begin
        if (ps_q == PS_LAST) begin
          logic [8:0] sec_nx;
          ps_d       = '0;
          sec_tick_d = 1'b1;
          sec_nx     = sexa_next(st_q, so_q);
          st_d       = sec_nx[7:4];
          so_d       = sec_nx[3:0];
          if (sec_nx[8]) begin
            min_tick_d = 1'b1;
            mt_d       = min_nx[7:4];
            mo_d       = min_nx[3:0];
            if (min_nx[8]) begin
              ht_d       = hour_nx[7:4];
              ho_d       = hour_nx[3:0];
              day_wrap_d = hour_nx[8];
            end
          end
        end else begin
          ps_d = ps_q + PS_ONE;
        end
      end
      default: ;
    endcase
    ht_disp_d = ht_display(ht_d);
  end

  // State and pulse registers with asynchronous reset to 00:00:00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q       <= '0;
      ht_q       <= 4'd0;
      ho_q       <= 4'd0;
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      ht_disp_q  <= HT_DISP_RST;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      ht_q       <= ht_d;
      ho_q       <= ho_d;
      mt_q       <= mt_d;
      mo_q       <= mo_d;
      st_q       <= st_d;
      so_q       <= so_d;
      ht_disp_q  <= ht_disp_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign hour_tens = ht_disp_q;
  assign hour_ones = ho_q;
  assign min_tens  = mt_q;
  assign min_ones  = mo_q;
  assign sec_tens  = st_q;
  assign sec_ones  = so_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;
  assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Testbench for bcd_time_counter: directed scenarios followed by randomized
// stimulus, all checked against a seconds-of-day reference model.
module tb_bcd_time_counter;

  localparam int CLK_DIV = 4;
  localparam int PS_W    = 3;

  logic       clk = 1'b0;
  logic       reset, run, set_mode, inc_min, inc_hour;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic       sec_tick, min_tick, day_wrap;

  int tests  = 0;
  int failed = 0;

  // Reference model: time as seconds since midnight plus prescaler count.
  int m_tod;
  int m_ps;
  bit m_st, m_mt, m_dw;

  bcd_time_counter #(.CLK_DIV(CLK_DIV), .PS_W(PS_W)) dut (
    .clk(clk), .reset(reset), .run(run), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hour(inc_hour),
    .hour_tens(hour_tens), .hour_ones(hour_ones),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .sec_tick(sec_tick), .min_tick(min_tick), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tod = 0; m_ps = 0; m_st = 0; m_mt = 0; m_dw = 0;
  endtask

  task automatic model_step();
    int h, mi, nt;
    m_st = 0; m_mt = 0; m_dw = 0;
    if (reset) begin
      model_reset();
    end else if (set_mode) begin
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      if (inc_min) begin mi = (mi + 1) % 60; m_mt = 1; end
      if (inc_hour) h = (h + 1) % 24;
      m_tod = h * 3600 + mi * 60;
      m_ps  = 0;
    end else if (run) begin
      if (m_ps == CLK_DIV - 1) begin
        m_ps  = 0;
        nt    = (m_tod + 1) % 86400;
        m_st  = 1;
        m_mt  = (nt % 60 == 0);
        m_dw  = (nt == 0);
        m_tod = nt;
      end else begin
        m_ps++;
      end
    end
  endtask

  function automatic int exp_ht();
    int t;
    t = m_tod / 36000;
`ifdef LEADING_ZERO_BLANK_EN
    if (t == 0) t = 'ha;
`endif
    return t;
  endfunction

  task automatic check_all(input string w);
    check({w, ".hour_tens"}, hour_tens, exp_ht());
    check({w, ".hour_ones"}, hour_ones, (m_tod / 3600) % 10);
    check({w, ".min_tens"},  min_tens,  ((m_tod / 60) % 60) / 10);
    check({w, ".min_ones"},  min_ones,  (m_tod / 60) % 10);
    check({w, ".sec_tens"},  sec_tens,  (m_tod % 60) / 10);
    check({w, ".sec_ones"},  sec_ones,  m_tod % 10);
    check({w, ".sec_tick"},  sec_tick,  m_st);
    check({w, ".min_tick"},  min_tick,  m_mt);
    check({w, ".day_wrap"},  day_wrap,  m_dw);
  endtask

  task automatic cycle(input string w);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(w);
  endtask

  task automatic cycles(input int n, input string w);
    for (int i = 0; i < n; i++) cycle(w);
  endtask

  // Enter set mode and pulse the buttons until the model shows hh:mm.
  task automatic set_time(input int h, input int mi);
    set_mode = 1; inc_min = 0; inc_hour = 0;
    cycle("set_enter");
    while (m_tod / 3600 != h) begin
      inc_hour = 1; cycle("set_hour"); inc_hour = 0;
    end
    while ((m_tod / 60) % 60 != mi) begin
      inc_min = 1; cycle("set_min"); inc_min = 0;
    end
    cycle("set_done");
  endtask

  initial begin
    reset = 1; run = 0; set_mode = 0; inc_min = 0; inc_hour = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");

    // Count a little, then reset asynchronously mid-count.
    reset = 0; run = 1;
    cycles(6, "pre_count");
    reset = 1;
    #1;
    model_reset();
    check_all("async_reset");
    cycle("reset_hold");
    reset = 0;

    // First tick four cycles after release.
    cycles(3, "first_sec");
    cycle("tick1");
    check("t4_sec_ones", sec_ones, 1);
    check("t4_sec_tick", sec_tick, 1);
    cycles(32, "count_9");
    check("t36_sec_ones", sec_ones, 9);
    cycles(4, "count_10");
    check("t40_sec_tens", sec_tens, 1);
    check("t40_sec_ones", sec_ones, 0);

    // Minute and hour carry from 00:59:59.
    set_time(0, 59);
    set_mode = 0;
    cycles(59 * CLK_DIV, "to_005959");
    check("at_005959_sec_ones", sec_ones, 9);
    cycles(CLK_DIV, "carry_hour");
    check("carry_hour_ones", hour_ones, 1);
    check("carry_min_tens", min_tens, 0);
    check("carry_sec_tick", sec_tick, 1);
    check("carry_min_tick", min_tick, 1);
    check("carry_day_wrap", day_wrap, 0);

    // Day wrap from 23:59:59.
    set_time(23, 59);
    set_mode = 0;
    cycles(59 * CLK_DIV, "to_235959");
    cycles(CLK_DIV, "day_wrap");
    check("wrap_day_wrap", day_wrap, 1);
    check("wrap_hour_ones", hour_ones, 0);
    check("wrap_min_tick", min_tick, 1);
    cycle("wrap_after");
    check("wrap_pulse_width", day_wrap, 0);

    // Set mode entered at 12:34:56.
    set_time(12, 34);
    set_mode = 0;
    cycles(56 * CLK_DIV, "to_123456");
    check("at_123456_sec_tens", sec_tens, 5);
    set_mode = 1;
    cycle("set_sec_clear");
    check("set_sec_tens", sec_tens, 0);
    check("set_sec_ones", sec_ones, 0);
    for (int i = 0; i < 20; i++) begin
      cycle("set_quiet");
      check("set_no_tick", sec_tick, 0);
    end
    for (int i = 0; i < 26; i++) begin
      inc_min = 1; cycle("inc26"); inc_min = 0; cycle("inc26_gap");
    end
    check("inc26_min_tens", min_tens, 0);
    check("inc26_min_ones", min_ones, 0);
    check("inc26_hour_ones", hour_ones, 2);

    // Both buttons at 23:59.
    set_time(23, 59);
    inc_min = 1; inc_hour = 1;
    cycle("both_inc");
    inc_min = 0; inc_hour = 0;
    check("both_hour_ones", hour_ones, 0);
    check("both_min_ones", min_ones, 0);
    check("both_day_wrap", day_wrap, 0);
    set_time(10, 0);
    check("ten_hour_tens", hour_tens, 1);

    // Hold mid-second, then resume for the remaining prescaler count.
    set_mode = 0; run = 1;
    cycles(6, "pre_hold");
    run = 0;
    for (int i = 0; i < 10; i++) begin
      inc_min = (i % 2 == 0);
      cycle("hold");
      check("hold_no_tick", sec_tick, 0);
    end
    inc_min = 0; run = 1;
    cycle("resume1");
    check("resume1_tick", sec_tick, 0);
    cycle("resume2");
    check("resume2_tick", sec_tick, 1);

    // Randomized stimulus.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1;
        #1;
        model_reset();
        check_all("rnd_async_reset");
        cycle("rnd_reset_hold");
        reset = 0;
      end
      if ($urandom_range(0, 149) == 0) set_mode = ~set_mode;
      run      = ($urandom_range(0, 9) != 0);
      inc_min  = ($urandom_range(0, 2) == 0);
      inc_hour = ($urandom_range(0, 3) == 0);
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
